// File: rtl/operand_loader.sv
// Debounced pushbutton that steps a three-state loader: it latches operand A,
// then operand B and an opcode, then holds exactly one unit enable high.
module operand_loader #(
    parameter int DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    input  logic [3:0] sw,
    input  logic [1:0] op_sel,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic       en_and,
    output logic       en_or,
    output logic       en_add,
    output logic       en_xor,
    output logic [1:0] state,
    output logic       valid
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    localparam logic [1:0] S_A    = 2'b00;
    localparam logic [1:0] S_B    = 2'b01;
    localparam logic [1:0] S_EXEC = 2'b10;

    // Bit order of the enable vector: {xor, add, or, and}.
    function automatic logic [3:0] decode_op(input logic [1:0] op);
        logic [3:0] en;
        case (op)
            2'b00:   en = 4'b0001;
            2'b01:   en = 4'b0010;
            2'b10:   en = 4'b0100;
            2'b11:   en = 4'b1000;
            default: en = 4'b0000;
        endcase
        return en;
    endfunction

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          clean_q, clean_d;
    logic          clean_prev_q;
    logic          press_q;
    logic [1:0]    state_q, state_d;
    logic [3:0]    a_q,     a_d;
    logic [3:0]    b_q,     b_d;
    logic [1:0]    opcode_q, opcode_d;
    logic [3:0]    en_q,    en_d;
    logic          valid_q, valid_d;

    // Debounce counter: the clean level flips only after DEB_CYCLES straight disagreements.
    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        if (sync_q[1] != clean_q) begin
            if (cnt_q == CNT_LAST) begin
                clean_d = sync_q[1];
                cnt_d   = {CW{1'b0}};
            end else begin
                cnt_d   = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = {CW{1'b0}};
        end
    end

    // Loader FSM: each press advances exactly one state; enables follow the latched opcode.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        opcode_d = opcode_q;
        en_d     = en_q;
        valid_d  = 1'b0;
        case (state_q)
            S_A: begin
                en_d = 4'b0000;
                if (press_q) begin
                    a_d     = sw;
                    state_d = S_B;
                end else begin
                    state_d = S_A;
                end
            end
            S_B: begin
                if (press_q) begin
                    b_d      = sw;
                    opcode_d = op_sel;
                    en_d     = decode_op(op_sel);
                    valid_d  = 1'b1;
                    state_d  = S_EXEC;
                end else begin
                    en_d    = 4'b0000;
                    state_d = S_B;
                end
            end
            S_EXEC: begin
                if (press_q) begin
                    en_d    = 4'b0000;
                    state_d = S_A;
                end else begin
                    en_d    = decode_op(opcode_q);
                    state_d = S_EXEC;
                end
            end
            default: begin
                en_d    = 4'b0000;
                state_d = S_A;
            end
        endcase
    end

    // State registers; reset clears everything without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= 2'b00;
            cnt_q        <= {CW{1'b0}};
            clean_q      <= 1'b0;
            clean_prev_q <= 1'b0;
            press_q      <= 1'b0;
            state_q      <= S_A;
            a_q          <= 4'b0000;
            b_q          <= 4'b0000;
            opcode_q     <= 2'b00;
            en_q         <= 4'b0000;
            valid_q      <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], btn};
            cnt_q        <= cnt_d;
            clean_q      <= clean_d;
            clean_prev_q <= clean_q;
            press_q      <= clean_q & ~clean_prev_q;
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            opcode_q     <= opcode_d;
            en_q         <= en_d;
            valid_q      <= valid_d;
        end
    end

    assign a      = a_q;
    assign b      = b_q;
    assign en_and = en_q[0];
    assign en_or  = en_q[1];
    assign en_add = en_q[2];
    assign en_xor = en_q[3];
    assign state  = state_q;
    assign valid  = valid_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader (DEB_CYCLES = 4) with hand-computed expectations.
module tb_operand_loader;

    logic       clk;
    logic       rst_n;
    logic       btn;
    logic [3:0] sw;
    logic [1:0] op_sel;
    logic [3:0] a;
    logic [3:0] b;
    logic       en_and;
    logic       en_or;
    logic       en_add;
    logic       en_xor;
    logic [1:0] state;
    logic       valid;

    int n_vec;
    int n_err;
    int valid_cnt;
    int add_cnt;
    int onehot_bad;
    int state_chg;
    logic [1:0] prev_state;

    operand_loader #(.DEB_CYCLES(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn    (btn),
        .sw     (sw),
        .op_sel (op_sel),
        .a      (a),
        .b      (b),
        .en_and (en_and),
        .en_or  (en_or),
        .en_add (en_add),
        .en_xor (en_xor),
        .state  (state),
        .valid  (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running observers sampled on the falling edge.
    initial begin
        valid_cnt  = 0;
        add_cnt    = 0;
        onehot_bad = 0;
        state_chg  = 0;
        prev_state = 2'b00;
    end
    always @(negedge clk) begin
        if ($countones({en_xor, en_add, en_or, en_and}) > 1) onehot_bad++;
        if (valid) valid_cnt++;
        if (en_add) add_cnt++;
        if (state != prev_state) state_chg++;
        prev_state = state;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press();
        btn = 1'b1;
        cycles(10);
        btn = 1'b0;
        cycles(10);
    endtask

    function automatic logic [3:0] ens();
        return {en_xor, en_add, en_or, en_and};
    endfunction

    int v0;
    int c0;
    int a0;

    initial begin
        n_vec  = 0;
        n_err  = 0;
        btn    = 1'b0;
        sw     = 4'b0000;
        op_sel = 2'b00;
        rst_n  = 1'b0;
        #23;
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_a", 32'(a), 32'h0);
        chk("rst_b", 32'(b), 32'h0);
        chk("rst_en", 32'(ens()), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        rst_n = 1'b1;
        cycles(3);

        // Bouncy first press latches A.
        sw = 4'b0101;
        c0 = state_chg;
        btn = 1'b1; cycles(1);
        btn = 1'b0; cycles(1);
        btn = 1'b1; cycles(10);
        btn = 1'b0; cycles(10);
        chk("bounce_state", 32'(state), 32'h1);
        chk("bounce_chg", 32'(state_chg - c0), 32'h1);
        chk("bounce_a", 32'(a), 32'h5);

        // Second press latches B and the OR opcode.
        v0 = valid_cnt;
        sw = 4'b0011;
        op_sel = 2'b01;
        press();
        chk("exec_state", 32'(state), 32'h2);
        chk("exec_a", 32'(a), 32'h5);
        chk("exec_b", 32'(b), 32'h3);
        chk("exec_en", 32'(ens()), 32'h2);
        chk("exec_valid_cnt", 32'(valid_cnt - v0), 32'h1);
        chk("exec_valid_now", 32'(valid), 32'h0);

        // Input changes while executing must be ignored.
        a0 = add_cnt;
        sw = 4'b1111;
        op_sel = 2'b10;
        cycles(5);
        chk("hold_en", 32'(ens()), 32'h2);
        chk("hold_a", 32'(a), 32'h5);
        chk("hold_b", 32'(b), 32'h3);

        // Third press returns to S_A keeping the operands.
        press();
        chk("ret_state", 32'(state), 32'h0);
        chk("ret_en", 32'(ens()), 32'h0);
        chk("ret_a", 32'(a), 32'h5);
        chk("ret_b", 32'(b), 32'h3);
        chk("ret_no_add", 32'(add_cnt - a0), 32'h0);

        // A glitch shorter than the debounce window is dropped.
        c0 = state_chg;
        btn = 1'b1; cycles(2);
        btn = 1'b0; cycles(15);
        chk("glitch_state", 32'(state), 32'h0);
        chk("glitch_chg", 32'(state_chg - c0), 32'h0);

        // Every opcode through a full sequence.
        for (int op = 0; op < 4; op++) begin
            sw = 4'(op + 6);
            op_sel = 2'(3 - op);
            press();
            sw = 4'(op + 1);
            op_sel = 2'(op);
            press();
            chk($sformatf("op%0d_state", op), 32'(state), 32'h2);
            chk($sformatf("op%0d_en", op), 32'(ens()), 32'(4'b0001 << op));
            chk($sformatf("op%0d_a", op), 32'(a), 32'(op + 6));
            chk($sformatf("op%0d_b", op), 32'(b), 32'(op + 1));
            press();
            chk($sformatf("op%0d_ret", op), 32'(ens()), 32'h0);
        end
        chk("onehot_viol", 32'(onehot_bad), 32'h0);

        // Asynchronous reset in S_EXEC, then reset release with the button held.
        sw = 4'b1001; press();
        sw = 4'b0110; op_sel = 2'b11; press();
        chk("pre_rst_en", 32'(ens()), 32'h8);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_en", 32'(ens()), 32'h0);
        chk("arst_a", 32'(a), 32'h0);
        chk("arst_b", 32'(b), 32'h0);
        chk("arst_state", 32'(state), 32'h0);
        btn = 1'b1;
        sw = 4'b1100;
        #2;
        rst_n = 1'b1;
        cycles(4);
        chk("held_early", 32'(state), 32'h0);
        cycles(10);
        chk("held_press", 32'(state), 32'h1);
        chk("held_a", 32'(a), 32'hC);
        btn = 1'b0;
        cycles(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
